circuito_jogo: RTL and testbench
================================

Name: circuito_jogo

Overview:
Top-level game controller for "Jogão da Velha" (ultimate tic-tac-toe): 9 macro boards, each a 3x3 grid of micro cells, 81 cells total.
- Two players alternate using 9 push buttons.
- A player first chooses a macro board, unless it was already forced by the previous move, then chooses a micro cell in it.
- Contains the FSM, the board storage, win/draw detection and the 7-segment debug outputs.

Parameters:
None.

Ports:
clock  in  1  system clock; all state updates on rising edge
reset  in  1  synchronous, active-high reset
iniciar  in  1  start/restart request
botoes  in  9  push buttons; botoes[k] selects position k+1 (1..9, row-major)
pronto  out  1  high while in state fim
leds  out  9  position indicators (see Behaviour)
db_tem_jogada  out  1  one-cycle pulse on a new button press
jogar_macro  out  1  high while waiting for a macro choice
jogar_micro  out  1  high while waiting for a micro choice
db_macro  out  7  7-seg of current macro index (0 = none)
db_micro  out  7  7-seg of last micro index played (0 = none)
db_estado  out  7  7-seg of FSM state code

Behaviour:
Interface rule (already decided): one clock; reset is synchronous and active-high.

Reset:
- State becomes inicial. All 81 cells become empty, all 9 macro statuses become open.
- Macro and micro registers become 0. Player becomes X.
- The button-edge register is cleared.
- Resulting outputs: pronto=0, leds=0, jogar_*=0, db_tem_jogada=0.
- Reset mid-game returns to inicial the same way.

Button input:
- anybtn = OR(botoes), registered once per cycle.
- db_tem_jogada = anybtn & ~anybtn_q, i.e. high for exactly one cycle at each press, however long the button is held.
- Position = 1 + index of the lowest set bit of botoes in that cycle.

FSM (hex state code shown on db_estado):
- inicial (0): iniciar=1 -> preparacao.
- preparacao (1): clear board, macro statuses, macro and micro registers; player=X -> espera_macro.
- espera_macro (2): jogar_macro=1. On a jogada pulse:
  - if the chosen macro is open, latch it -> registra_macro;
  - if it is closed (won or full), ignore the press and stay.
- registra_macro (3): -> espera_micro.
- espera_micro (4): jogar_micro=1. On a jogada pulse:
  - if the cell in the current macro is empty, latch micro -> registra_micro;
  - otherwise ignore and stay.
- registra_micro (5): write the current player into the cell -> verifica_macro.
- verifica_macro (6): evaluate the current macro:
  - three in a row (8 lines) for the mover -> status = won by the mover;
  - else all 9 cells occupied -> status = full;
  - -> verifica_fim.
- verifica_fim (7): game over if the mover owns 3 macros in a line, or all 9 macros are closed -> fim; else -> troca_jogador.
- troca_jogador (8): toggle player. Then:
  - if macro[micro] is open: macro <= micro -> espera_micro (macro choice is skipped);
  - else macro <= 0 -> espera_macro.
- fim (F): pronto=1. iniciar=1 -> preparacao.

Other rules:
- iniciar is ignored in every state except inicial and fim.
- Presses outside espera_macro/espera_micro are ignored.
- Exactly one move is accepted per press.

leds:
- espera_macro: leds[i]=1 iff macro i+1 is open.
- espera_micro through troca_jogador: leds[i]=1 iff cell i+1 of the current macro is occupied.
- inicial, preparacao, fim: 0.

7-segment encoding:
- Active-low, bit0=a through bit6=g, standard hex glyphs.
- Examples: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 8=0000000, F=0001110.

Outputs are combinational from registered state. Latency from a press edge to the next waiting state:
- macro choice: 2 cycles;
- micro choice: 5 cycles.

Test Plan:
1. Reset:
   - pulse reset 1 cycle -> db_estado=1000000 (state 0), pronto=0, jogar_macro=0, jogar_micro=0, leds=0.
2. Start:
   - iniciar=1 for 5 cycles -> passes state 1 -> state 2; jogar_macro=1, leds=9'h1FF, db_macro shows 0.
3. Macro choice:
   - botoes=9'b000001000 held 20 cycles -> db_tem_jogada pulses exactly once;
   - db_macro=0011001 (4), then state 4 with jogar_micro=1 and leds=0.
4. Micro into an open macro:
   - botoes=9'b000000100 for 20 cycles -> cell 3 of macro 4 = X; db_micro shows 3;
   - the FSM returns directly to espera_micro with db_macro=0110000 (3), jogar_macro=0, player=O.
5. Forced-macro move:
   - botoes=9'b000000010 -> O is written to cell 2 of macro 3 with no macro step; next db_macro shows 2.
6. Illegal and closed cases:
   - pressing an occupied cell leaves the state at 4;
   - X completing cells 1,2,3 of a macro marks it won;
   - a later move forced into that macro lands in espera_macro, where pressing the won macro is ignored.

Source files
------------

// File: rtl/circuito_jogo.sv
// Ultimate tic-tac-toe controller: 9 macro boards of 3x3 micro cells.
// Holds the sequencing FSM, the 81-cell board, per-macro status, win/draw
// detection and the 7-segment debug outputs.
//
// state          | code | meaning
// ---------------+------+----------------------------------------------
// inicial        |  0   | idle after reset, waits for iniciar
// preparacao     |  1   | clear board, statuses, registers; player = X
// espera_macro   |  2   | wait for a press choosing an open macro
// registra_macro |  3   | macro latched
// espera_micro   |  4   | wait for a press choosing an empty cell
// registra_micro |  5   | write current player into the cell
// verifica_macro |  6   | mark current macro won or full
// verifica_fim   |  7   | game over if macro line or all macros closed
// troca_jogador  |  8   | toggle player, pick next macro (forced or free)
// fim            |  F   | game over, waits for iniciar
module circuito_jogo (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic [8:0] botoes,
    output logic       pronto,
    output logic [8:0] leds,
    output logic       db_tem_jogada,
    output logic       jogar_macro,
    output logic       jogar_micro,
    output logic [6:0] db_macro,
    output logic [6:0] db_micro,
    output logic [6:0] db_estado
);

    typedef enum logic [3:0] {
        INICIAL        = 4'h0,
        PREPARACAO     = 4'h1,
        ESPERA_MACRO   = 4'h2,
        REGISTRA_MACRO = 4'h3,
        ESPERA_MICRO   = 4'h4,
        REGISTRA_MICRO = 4'h5,
        VERIFICA_MACRO = 4'h6,
        VERIFICA_FIM   = 4'h7,
        TROCA_JOGADOR  = 4'h8,
        FIM            = 4'hF
    } estado_t;

    estado_t estado, proximo;

    // Cell and macro status share one encoding: 00 empty/open, 01 X, 10 O, 11 full.
    logic [1:0] celulas [9][9];
    logic [1:0] macro_status [9];
    logic [3:0] macro_reg;
    logic [3:0] micro_reg;
    logic       jogador;

    logic       anybtn, anybtn_q, jogada;
    logic [3:0] pos_idx;
    logic [3:0] macro_idx, micro_idx;
    logic [1:0] marca;
    logic [8:0] cur_occ, cur_own, macro_own, macro_closed;

    logic limpar, ld_macro, ld_micro, grava, avalia, troca;

    function automatic logic tem_linha(input logic [8:0] b);
        return (b[0] & b[1] & b[2]) | (b[3] & b[4] & b[5]) | (b[6] & b[7] & b[8]) |
               (b[0] & b[3] & b[6]) | (b[1] & b[4] & b[7]) | (b[2] & b[5] & b[8]) |
               (b[0] & b[4] & b[8]) | (b[2] & b[4] & b[6]);
    endfunction

    function automatic logic [6:0] hex7(input logic [3:0] d);
        case (d)
            4'h0: hex7 = 7'b1000000;
            4'h1: hex7 = 7'b1111001;
            4'h2: hex7 = 7'b0100100;
            4'h3: hex7 = 7'b0110000;
            4'h4: hex7 = 7'b0011001;
            4'h5: hex7 = 7'b0010010;
            4'h6: hex7 = 7'b0000010;
            4'h7: hex7 = 7'b1111000;
            4'h8: hex7 = 7'b0000000;
            4'h9: hex7 = 7'b0010000;
            4'hA: hex7 = 7'b0001000;
            4'hB: hex7 = 7'b0000011;
            4'hC: hex7 = 7'b1000110;
            4'hD: hex7 = 7'b0100001;
            4'hE: hex7 = 7'b0000110;
            default: hex7 = 7'b0001110;
        endcase
    endfunction

    assign anybtn        = |botoes;
    assign jogada        = anybtn & ~anybtn_q;
    assign db_tem_jogada = jogada;
    assign marca         = jogador ? 2'b10 : 2'b01;
    // Zero-based indices; a zero register maps to index 0 but is never used then.
    assign macro_idx     = (macro_reg != 4'd0) ? macro_reg - 4'd1 : 4'd0;
    assign micro_idx     = (micro_reg != 4'd0) ? micro_reg - 4'd1 : 4'd0;

    // Lowest set button wins when several are held together.
    always_comb begin
        pos_idx = 4'd0;
        for (int k = 8; k >= 0; k--) begin
            if (botoes[k]) pos_idx = 4'(k);
        end
    end

    // Per-position views of the current macro and of the macro statuses.
    always_comb begin
        cur_occ      = '0;
        cur_own      = '0;
        macro_own    = '0;
        macro_closed = '0;
        for (int i = 0; i < 9; i++) begin
            cur_occ[i]      = (celulas[macro_idx][i] != 2'b00);
            cur_own[i]      = (celulas[macro_idx][i] == marca);
            macro_own[i]    = (macro_status[i] == marca);
            macro_closed[i] = (macro_status[i] != 2'b00);
        end
    end

    // Button edge register.
    always_ff @(posedge clock) begin
        if (reset) anybtn_q <= 1'b0;
        else       anybtn_q <= anybtn;
    end

    // State register.
    always_ff @(posedge clock) begin
        if (reset) estado <= INICIAL;
        else       estado <= proximo;
    end

    // Next state, datapath strobes and status outputs.
    always_comb begin
        proximo     = estado;
        limpar      = 1'b0;
        ld_macro    = 1'b0;
        ld_micro    = 1'b0;
        grava       = 1'b0;
        avalia      = 1'b0;
        troca       = 1'b0;
        pronto      = 1'b0;
        jogar_macro = 1'b0;
        jogar_micro = 1'b0;
        leds        = '0;
        case (estado)
            INICIAL: begin
                if (iniciar) proximo = PREPARACAO;
            end
            PREPARACAO: begin
                limpar  = 1'b1;
                proximo = ESPERA_MACRO;
            end
            ESPERA_MACRO: begin
                jogar_macro = 1'b1;
                leds        = ~macro_closed;
                if (jogada && !macro_closed[pos_idx]) begin
                    ld_macro = 1'b1;
                    proximo  = REGISTRA_MACRO;
                end
            end
            REGISTRA_MACRO: begin
                proximo = ESPERA_MICRO;
            end
            ESPERA_MICRO: begin
                jogar_micro = 1'b1;
                leds        = cur_occ;
                if (jogada && !cur_occ[pos_idx]) begin
                    ld_micro = 1'b1;
                    proximo  = REGISTRA_MICRO;
                end
            end
            REGISTRA_MICRO: begin
                leds    = cur_occ;
                grava   = 1'b1;
                proximo = VERIFICA_MACRO;
            end
            VERIFICA_MACRO: begin
                leds    = cur_occ;
                avalia  = 1'b1;
                proximo = VERIFICA_FIM;
            end
            VERIFICA_FIM: begin
                leds = cur_occ;
                if (tem_linha(macro_own) || (&macro_closed)) proximo = FIM;
                else                                         proximo = TROCA_JOGADOR;
            end
            TROCA_JOGADOR: begin
                leds    = cur_occ;
                troca   = 1'b1;
                proximo = macro_closed[micro_idx] ? ESPERA_MACRO : ESPERA_MICRO;
            end
            FIM: begin
                pronto = 1'b1;
                if (iniciar) proximo = PREPARACAO;
            end
            default: proximo = INICIAL;
        endcase
    end

    // Board, macro statuses, move registers and player.
    always_ff @(posedge clock) begin
        if (reset || limpar) begin
            for (int m = 0; m < 9; m++) begin
                macro_status[m] <= 2'b00;
                for (int c = 0; c < 9; c++) celulas[m][c] <= 2'b00;
            end
            macro_reg <= 4'd0;
            micro_reg <= 4'd0;
            jogador   <= 1'b0;
        end else begin
            if (ld_macro) macro_reg <= pos_idx + 4'd1;
            if (ld_micro) micro_reg <= pos_idx + 4'd1;
            if (grava)    celulas[macro_idx][micro_idx] <= marca;
            if (avalia) begin
                if (tem_linha(cur_own)) macro_status[macro_idx] <= marca;
                else if (&cur_occ)      macro_status[macro_idx] <= 2'b11;
            end
            if (troca) begin
                jogador   <= ~jogador;
                macro_reg <= macro_closed[micro_idx] ? 4'd0 : micro_reg;
            end
        end
    end

    assign db_macro  = hex7(macro_reg);
    assign db_micro  = hex7(micro_reg);
    assign db_estado = hex7(estado);

endmodule

// File: tb/tb_circuito_jogo.sv
// Bench for circuito_jogo: a game-level reference model predicts the waiting
// state reached after each press; a monitor compares on every press pulse.
module tb_circuito_jogo;

    logic       clock = 1'b0;
    logic       reset, iniciar;
    logic [8:0] botoes;
    logic       pronto, db_tem_jogada, jogar_macro, jogar_micro;
    logic [8:0] leds;
    logic [6:0] db_macro, db_micro, db_estado;

    circuito_jogo dut (
        .clock(clock), .reset(reset), .iniciar(iniciar), .botoes(botoes),
        .pronto(pronto), .leds(leds), .db_tem_jogada(db_tem_jogada),
        .jogar_macro(jogar_macro), .jogar_micro(jogar_micro),
        .db_macro(db_macro), .db_micro(db_micro), .db_estado(db_estado)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [3:0] st;
        logic [8:0] leds;
        logic [3:0] mac;
        logic [3:0] mic;
        int         lat;
    } exp_t;

    exp_t q[$];
    int   ncheck = 0, nfail = 0, presses = 0, pulses = 0;

    logic [6:0] seg [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                             7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    int linhas [24] = '{0,1,2, 3,4,5, 6,7,8, 0,3,6, 1,4,7, 2,5,8, 0,4,8, 2,4,6};

    // Reference game state: board values 0 empty, 1 X, 2 O; mstat 0 open, 1/2 won, 3 full.
    int board [9][9];
    int mstat [9];
    int cur, last, player, phase;   // phase: 0 choose macro, 1 choose micro, 2 over

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        ncheck++;
        if (act !== req) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic bit linha(input bit [8:0] b);
        for (int l = 0; l < 8; l++)
            if (b[linhas[3*l]] && b[linhas[3*l+1]] && b[linhas[3*l+2]]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [8:0] occ(input int m);
        logic [8:0] r = '0;
        for (int i = 0; i < 9; i++) r[i] = (board[m-1][i] != 0);
        return r;
    endfunction

    function automatic logic [8:0] openmask();
        logic [8:0] r = '0;
        for (int i = 0; i < 9; i++) r[i] = (mstat[i] == 0);
        return r;
    endfunction

    task automatic model_reset();
        for (int m = 0; m < 9; m++) begin
            mstat[m] = 0;
            for (int c = 0; c < 9; c++) board[m][c] = 0;
        end
        cur = 0; last = 0; player = 0; phase = 0;
    endtask

    function automatic int pick();
        int cand[$];
        if ($urandom_range(0, 3) == 0) return int'($urandom_range(1, 9));
        for (int i = 0; i < 9; i++) begin
            if (phase == 0 && mstat[i] == 0) cand.push_back(i + 1);
            if (phase == 1 && board[cur-1][i] == 0) cand.push_back(i + 1);
        end
        if (cand.size() == 0) return 1;
        return cand[$urandom_range(0, cand.size() - 1)];
    endfunction

    // Apply a press to the model, queue the expected outcome, then drive the buttons.
    task automatic do_press(input int p, input bit extra);
        exp_t e;
        int mark;
        logic [8:0] val, hi;
        bit [8:0] own;
        e.lat = 1;
        if (phase == 0) begin
            if (mstat[p-1] == 0) begin
                cur = p; phase = 1; e.st = 4'h4; e.leds = occ(cur); e.lat = 2;
            end else begin
                e.st = 4'h2; e.leds = openmask();
            end
        end else begin
            if (board[cur-1][p-1] != 0) begin
                e.st = 4'h4; e.leds = occ(cur);
            end else begin
                mark = player + 1;
                board[cur-1][p-1] = mark;
                last = p;
                for (int i = 0; i < 9; i++) own[i] = (board[cur-1][i] == mark);
                if (linha(own)) mstat[cur-1] = mark;
                else if (occ(cur) == 9'h1FF) mstat[cur-1] = 3;
                for (int i = 0; i < 9; i++) own[i] = (mstat[i] == mark);
                if (linha(own) || openmask() == 9'h000) begin
                    phase = 2; e.st = 4'hF; e.leds = '0; e.lat = 4;
                end else begin
                    player = 1 - player;
                    e.lat = 5;
                    if (mstat[p-1] == 0) begin
                        cur = p; e.st = 4'h4; e.leds = occ(cur);
                    end else begin
                        cur = 0; phase = 0; e.st = 4'h2; e.leds = openmask();
                    end
                end
            end
        end
        e.mac = 4'(cur);
        e.mic = 4'(last);
        q.push_back(e);
        presses++;
        val = 9'd1 << (p - 1);
        hi  = 9'h1FF << p;
        if (extra) val = val | (hi & 9'($urandom));
        @(posedge clock); #1 botoes = val;
        repeat ($urandom_range(1, 4)) @(posedge clock);
        #1 botoes = '0;
        repeat (8) @(posedge clock);
    endtask

    task automatic start(input int cycles);
        @(posedge clock); #1 iniciar = 1'b1;
        repeat (cycles) @(posedge clock);
        #1 iniciar = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        chk("start_state", db_estado, seg[2]);
        chk("start_jogar_macro", jogar_macro, 1'b1);
        chk("start_leds", leds, 9'h1FF);
        chk("start_db_macro", db_macro, seg[0]);
        chk("start_db_micro", db_micro, seg[0]);
    endtask

    task automatic check_reset_state();
        @(negedge clock);
        chk("reset_state", db_estado, seg[0]);
        chk("reset_pronto", pronto, 1'b0);
        chk("reset_jogar_macro", jogar_macro, 1'b0);
        chk("reset_jogar_micro", jogar_micro, 1'b0);
        chk("reset_leds", leds, 9'h000);
        chk("reset_tem_jogada", db_tem_jogada, 1'b0);
    endtask

    // Monitor: on each press pulse, wait for the next waiting state and compare.
    initial begin
        exp_t e;
        int lat;
        forever begin
            @(negedge clock);
            if (db_tem_jogada === 1'b1) begin
                pulses++;
                lat = 0;
                do begin
                    @(negedge clock);
                    lat++;
                end while (!(jogar_macro || jogar_micro || pronto) && lat < 12);
                if (q.size() == 0) begin
                    chk("unexpected_press", pulses, presses);
                end else begin
                    e = q.pop_front();
                    chk("move_state", db_estado, seg[e.st]);
                    chk("move_leds", leds, e.leds);
                    chk("move_db_macro", db_macro, seg[e.mac]);
                    chk("move_db_micro", db_micro, seg[e.mic]);
                    chk("move_latency", lat, e.lat);
                    chk("move_pronto", pronto, (e.st == 4'hF));
                end
            end
        end
    end

    initial begin
        #5ms;
        nfail++;
        $display("FAIL watchdog: got timeout expected finish");
        $display("End of test - %0d assertions evaluated, %0d failures", ncheck, nfail);
        $finish;
    end

    initial begin
        int n;
        reset = 1'b1; iniciar = 1'b0; botoes = '0;
        model_reset();
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        check_reset_state();
        start(5);

        // Opening: macro 4, cell 3 (forces macro 3), cell 2 (forces macro 2),
        // cell 3 (forces macro 3 again), then the occupied cell 2 is refused.
        do_press(4, 1'b0);
        do_press(3, 1'b0);
        do_press(2, 1'b0);
        do_press(3, 1'b1);
        do_press(2, 1'b0);

        // iniciar is ignored while a micro choice is pending.
        @(posedge clock); #1 iniciar = 1'b1;
        repeat (2) @(posedge clock);
        #1 iniciar = 1'b0;
        @(negedge clock);
        chk("iniciar_ignored", db_estado, seg[4]);

        for (int g = 0; g < 3; g++) begin
            if (g > 0) begin
                model_reset();
                start(1);
            end
            n = 0;
            while (phase != 2 && n < 300) begin
                do_press(pick(), ($urandom_range(0, 2) == 0));
                n++;
                if (g == 1 && n == 15 && phase != 2) begin
                    @(posedge clock); #1 reset = 1'b1;
                    @(posedge clock); #1 reset = 1'b0;
                    check_reset_state();
                    model_reset();
                    start(1);
                end
            end
            @(negedge clock);
            chk("game_over_pronto", pronto, 1'b1);
            chk("game_over_state", db_estado, seg[15]);
        end

        chk("queue_drained", q.size(), 0);
        chk("one_pulse_per_press", pulses, presses);
        $display("End of test - %0d assertions evaluated, %0d failures", ncheck, nfail);
        $finish;
    end

endmodule
